markov_chain_merge: RTL



---
 rtl/markov_chain_merge_pkg.sv | 46 ++++
 rtl/markov_seq_match.sv | 37 +++
 rtl/markov_chain_merge.sv | 106 ++++++++++
 3 files changed

// File: rtl/markov_chain_merge_pkg.sv
// Shared sizing, entry layout, FSM encoding and count arithmetic for markov_chain_merge.
// Optional build macro MARKOV_MERGE_SAT_EN: count additions saturate instead of wrapping.
// Pure declarations; no timing or flow control of its own.
package markov_chain_merge_pkg;

  localparam int NOTE_BIT_LEN     = 4;
  localparam int DELAY_BIT_LEN    = 4;
  localparam int SEQUENCE_LEN     = 3;
  localparam int SEQ_CNT_BIT_LEN  = 4;
  localparam int MARKOV_CHAIN_LEN = 8;

  // Derived widths: sequence field, whole entry, merged table depth, index/count widths.
  localparam int SEQ_BIT_LEN = SEQUENCE_LEN * (NOTE_BIT_LEN + DELAY_BIT_LEN);
  localparam int ENTRY_W     = SEQ_BIT_LEN + SEQ_CNT_BIT_LEN;
  localparam int OUT_LEN     = 2 * MARKOV_CHAIN_LEN;
  localparam int IDX_W       = $clog2(OUT_LEN);
  localparam int CNT_W       = $clog2(OUT_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Count lives in the low bits, sequence above it.
  typedef struct packed {
    logic [SEQ_BIT_LEN-1:0]     seq;
    logic [SEQ_CNT_BIT_LEN-1:0] cnt;
  } entry_t;

  // Merge two occurrence counts; saturating or modulo depending on the build.
  function automatic logic [SEQ_CNT_BIT_LEN-1:0] add_cnt(
    input logic [SEQ_CNT_BIT_LEN-1:0] x,
    input logic [SEQ_CNT_BIT_LEN-1:0] y
  );
`ifdef MARKOV_MERGE_SAT_EN
    logic [SEQ_CNT_BIT_LEN:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[SEQ_CNT_BIT_LEN] ? {SEQ_CNT_BIT_LEN{1'b1}} : s[SEQ_CNT_BIT_LEN-1:0];
`else
    return x + y;
`endif
  endfunction

endpackage

// File: rtl/markov_seq_match.sv
// Parallel sequence lookup of one key against every valid merged-table slot.
// Latency: purely combinational; lowest matching slot wins.
// No flow control; the caller qualifies valid slots with valid_count.
module markov_seq_match
  import markov_chain_merge_pkg::*;
(
  input  logic [OUT_LEN*ENTRY_W-1:0] table_flat,
  input  logic [SEQ_BIT_LEN-1:0]     key,
  input  logic [CNT_W-1:0]           valid_count,
  output logic                       hit,
  output logic [IDX_W-1:0]           hit_index
);

  logic [OUT_LEN-1:0] match;

  // Compare the key with each slot's sequence field, masked to slots below valid_count.
  always_comb begin
    match = '0;
    for (int j = 0; j < OUT_LEN; j++) begin
      match[j] = (CNT_W'(j) < valid_count) &&
                 (table_flat[j*ENTRY_W + SEQ_CNT_BIT_LEN +: SEQ_BIT_LEN] == key);
    end
  end

  // Priority encode: scanning downwards lets the lowest matching slot win.
  always_comb begin
    hit       = 1'b0;
    hit_index = '0;
    for (int j = OUT_LEN - 1; j >= 0; j--) begin
      if (match[j]) begin
        hit       = 1'b1;
        hit_index = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/markov_chain_merge.sv
// Merges two Markov chain tables into one double-size table, summing counts of equal sequences.
// Latency: start sampled in IDLE to done high = 2*MARKOV_CHAIN_LEN+2 edges; build macro MARKOV_MERGE_SAT_EN selects saturating counts.
// Level start/done handshake: done holds while start stays high; inputs sampled only in LOAD.
module markov_chain_merge
  import markov_chain_merge_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [MARKOV_CHAIN_LEN*ENTRY_W-1:0]   chain_a,
  input  logic [MARKOV_CHAIN_LEN*ENTRY_W-1:0]   chain_b,
  output logic [OUT_LEN*ENTRY_W-1:0]            chain_out,
  output logic [CNT_W-1:0]                      out_count,
  output logic                                  done
);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  entry_t           src     [OUT_LEN];
  entry_t           out_tab [OUT_LEN];
  entry_t           cur;
  logic             hit;
  logic [IDX_W-1:0] hit_index;
  logic             append_en;

  assign cur       = src[idx];
  assign append_en = (state == ST_SCAN) && (cur.cnt != '0) && !hit;

  // Flatten the merged table onto the output bus, slot j at [j*ENTRY_W +: ENTRY_W].
  always_comb begin
    chain_out = '0;
    for (int j = 0; j < OUT_LEN; j++) begin
      chain_out[j*ENTRY_W +: ENTRY_W] = out_tab[j];
    end
  end

  markov_seq_match u_match (
    .table_flat  (chain_out),
    .key         (cur.seq),
    .valid_count (out_count),
    .hit         (hit),
    .hit_index   (hit_index)
  );

  // Next-state and done decode.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_SCAN;
      ST_SCAN: if (idx == IDX_W'(OUT_LEN - 1)) state_nxt = ST_DONE;
      ST_DONE: begin
        done = 1'b1;
        if (!start) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, source snapshot and one-entry-per-cycle merge into the output table.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      out_count <= '0;
      for (int j = 0; j < OUT_LEN; j++) begin
        src[j]     <= '0;
        out_tab[j] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        ST_LOAD: begin
          idx       <= '0;
          out_count <= '0;
          for (int i = 0; i < MARKOV_CHAIN_LEN; i++) begin
            src[i]                    <= chain_a[i*ENTRY_W +: ENTRY_W];
            src[MARKOV_CHAIN_LEN + i] <= chain_b[i*ENTRY_W +: ENTRY_W];
          end
          for (int j = 0; j < OUT_LEN; j++) begin
            out_tab[j] <= '0;
          end
        end
        ST_SCAN: begin
          idx <= idx + 1'b1;
          if (cur.cnt != '0) begin
            if (hit) begin
              out_tab[hit_index].cnt <= add_cnt(out_tab[hit_index].cnt, cur.cnt);
            end else begin
              out_tab[out_count[IDX_W-1:0]] <= cur;
              out_count                     <= out_count + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Both sources together hold at most OUT_LEN entries, so a full table can never take an append.
  append_in_range: assert property (@(posedge clk) disable iff (!reset)
    !(append_en && (out_count == CNT_W'(OUT_LEN))));

endmodule
